// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//
// Register scoreboard and issue controller sitting between ID and EXE.
// Every issued instruction that writes a register bumps that register's
// pending counter; every retiring writeback drops it. The instruction in ID
// is held while any of its sources is pending, or while its destination
// counter is full, and is released to EXE only when EXE can take it.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   flush              kills the instruction held in ID (no counter effect)
//   id_valid           ID holds a decoded instruction
//   id_r_addr1/2       source registers (0 = unused)
//   id_w_addr          destination register (0 = no write)
//   exe_allow_in       EXE can accept this cycle
//   wb_valid/wb_w_addr retiring register write
//   id_ready_go        no hazard on the held instruction
//   id_to_exe_valid    issue fires this cycle
//   pending            bit i set while register i has writes in flight
//   stall_cycles       saturating count of hazard-stall cycles
//
// Build option
//   SB_WAW_CHECK_EN    when defined, a pending write to the destination
//                      register is also a hazard (one write in flight per reg)
// ---------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [4:0]             id_r_addr1,
    input  logic [4:0]             id_r_addr2,
    input  logic [4:0]             id_w_addr,
    input  logic                   exe_allow_in,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_w_addr,
    output logic                   id_ready_go,
    output logic                   id_to_exe_valid,
    output logic [31:0]            pending,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [CNT_W-1:0]       cnt_q [32];
    logic [CNT_W-1:0]       cnt_d [32];
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    logic raw_hazard;
    logic sat_hazard;
    logic waw_hazard;
    logic hazard;
    logic issue;

    // Hazards look only at registered counters; a same-cycle writeback
    // does not release a dependent instruction.
    always_comb begin
        raw_hazard = ((id_r_addr1 != 5'd0) && (cnt_q[id_r_addr1] != '0)) ||
                     ((id_r_addr2 != 5'd0) && (cnt_q[id_r_addr2] != '0));
        sat_hazard = (id_w_addr != 5'd0) && (cnt_q[id_w_addr] == CNT_MAX);
`ifdef SB_WAW_CHECK_EN
        waw_hazard = (id_w_addr != 5'd0) && (cnt_q[id_w_addr] != '0);
`else
        waw_hazard = 1'b0;
`endif
        hazard          = raw_hazard | sat_hazard | waw_hazard;
        issue           = id_valid & ~hazard & exe_allow_in & ~flush;
        id_ready_go     = ~hazard;
        id_to_exe_valid = issue;
    end

    // Increment on issue, decrement on writeback; both together cancel.
    // A writeback to an empty counter is ignored rather than wrapping.
    always_comb begin
        logic inc;
        logic dec;
        cnt_d[0] = '0;
        pending  = '0;
        for (int i = 1; i < 32; i++) begin
            inc        = issue && (id_w_addr == 5'(i));
            dec        = wb_valid && (wb_w_addr == 5'(i)) && (cnt_q[i] != '0);
            cnt_d[i]   = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            pending[i] = (cnt_q[i] != '0);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (id_valid && hazard && !flush && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_q <= stall_d;
        end
    end

`ifndef SYNTHESIS
    // Retiring a write that was never issued means the pipeline lost track
    // of an instruction somewhere upstream.
    always @(posedge clk) begin
        if (!reset && wb_valid && (wb_w_addr != 5'd0)) begin
            assert (cnt_q[wb_w_addr] != '0)
                else $error("issue_scoreboard: writeback to r%0d with no pending write", wb_w_addr);
        end
    end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

    localparam int CNT_MAX   = 3;
    localparam int STALL_MAX = 65535;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_r_addr1;
    logic [4:0]  id_r_addr2;
    logic [4:0]  id_w_addr;
    logic        exe_allow_in;
    logic        wb_valid;
    logic [4:0]  wb_w_addr;
    logic        id_ready_go;
    logic        id_to_exe_valid;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    issue_scoreboard #(.CNT_W(2), .STALL_CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_r_addr1      (id_r_addr1),
        .id_r_addr2      (id_r_addr2),
        .id_w_addr       (id_w_addr),
        .exe_allow_in    (exe_allow_in),
        .wb_valid        (wb_valid),
        .wb_w_addr       (wb_w_addr),
        .id_ready_go     (id_ready_go),
        .id_to_exe_valid (id_to_exe_valid),
        .pending         (pending),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Reference state: number of writes in flight per register, stall count.
    int m_cnt [32];
    int m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_hazard();
        bit h;
        h = 0;
        if (id_r_addr1 != 0 && m_cnt[id_r_addr1] > 0) h = 1;
        if (id_r_addr2 != 0 && m_cnt[id_r_addr2] > 0) h = 1;
        if (id_w_addr != 0 && m_cnt[id_w_addr] == CNT_MAX) h = 1;
`ifdef SB_WAW_CHECK_EN
        if (id_w_addr != 0 && m_cnt[id_w_addr] > 0) h = 1;
`endif
        return h;
    endfunction

    // Compare mid-cycle against the model, then advance the model to the
    // state the next rising edge will produce.
    always @(negedge clk) begin
        bit          h;
        bit          iss;
        logic [31:0] exp_pend;
        h   = m_hazard();
        iss = id_valid && !h && exe_allow_in && !flush;
        exp_pend = '0;
        for (int i = 1; i < 32; i++) exp_pend[i] = (m_cnt[i] > 0);
        if (chk_en) begin
            check("ready_go", 32'(id_ready_go), 32'(!h));
            check("to_exe_valid", 32'(id_to_exe_valid), 32'(iss));
            check("pending", pending, exp_pend);
            check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_stall = 0;
        end else begin
            if (id_valid && h && !flush && m_stall < STALL_MAX) m_stall++;
            if (wb_valid && wb_w_addr != 0 && m_cnt[wb_w_addr] > 0) m_cnt[wb_w_addr]--;
            if (iss && id_w_addr != 0) m_cnt[id_w_addr]++;
        end
    end

    task automatic drive(input bit v, input bit fl, input int r1, input int r2,
                         input int w, input bit allow, input bit wbv, input int wba);
        id_valid     = v;
        flush        = fl;
        id_r_addr1   = 5'(r1);
        id_r_addr2   = 5'(r2);
        id_w_addr    = 5'(w);
        exe_allow_in = allow;
        wb_valid     = wbv;
        wb_w_addr    = 5'(wba);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_stall = 0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1;

        // Reset state
        #2;
        check("rst_pending", pending, 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_ready", 32'(id_ready_go), 32'd1);
        check("rst_valid", 32'(id_to_exe_valid), 32'd0);
        tick();

        // RAW stall on r5, released the cycle after its writeback
        drive(1, 0, 0, 0, 5, 1, 0, 0);
        #2; check("raw_prod_issue", 32'(id_to_exe_valid), 32'd1);
        tick();
        drive(1, 0, 5, 0, 0, 1, 0, 0);
        #2; check("raw_stall", 32'(id_ready_go), 32'd0);
        check("raw_pend5", 32'(pending[5]), 32'd1);
        tick();
        #2; check("raw_stall2", 32'(id_to_exe_valid), 32'd0);
        tick();
        drive(1, 0, 5, 0, 0, 1, 1, 5);
        #2; check("raw_wb_same_cycle", 32'(id_ready_go), 32'd0);
        tick();
        drive(1, 0, 5, 0, 0, 1, 0, 0);
        #2; check("raw_release", 32'(id_to_exe_valid), 32'd1);
        check("raw_stall_count", 32'(stall_cycles), 32'd3);
        tick();

        // Simultaneous issue and writeback on r7
        drive(1, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 7, 1, 1, 7);
        #2; check("simul_issue", 32'(id_to_exe_valid), 32'd1);
        tick();
        idle();
        #2; check("simul_pend7", 32'(pending[7]), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1, 7);
        tick();
        idle();
        #2; check("r7_drained", 32'(pending[7]), 32'd0);

        // Register 0 is never tracked
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        #2; check("r0_ready", 32'(id_ready_go), 32'd1);
        check("r0_pend", 32'(pending[0]), 32'd0);
        tick();

        // Flush kills the held instruction without touching counters
        drive(1, 1, 0, 0, 11, 1, 0, 0);
        #2; check("flush_no_issue", 32'(id_to_exe_valid), 32'd0);
        check("flush_ready", 32'(id_ready_go), 32'd1);
        tick();
        idle();
        #2; check("flush_pend11", 32'(pending[11]), 32'd0);
        tick();

        // EXE back-pressure: no hazard, but no issue either
        drive(1, 0, 0, 0, 12, 0, 0, 0);
        #2; check("bp_no_issue", 32'(id_to_exe_valid), 32'd0);
        tick();
        idle();
        tick();

        // Saturation (default build) / WAW (SB_WAW_CHECK_EN) on r9
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 9, 1, 0, 0);
`ifdef SB_WAW_CHECK_EN
            #2; check("waw_ready", 32'(id_ready_go), 32'(k == 0));
`else
            #2; check("sat_ready", 32'(id_ready_go), 32'(k < 3));
`endif
            tick();
        end
        drive(1, 0, 0, 0, 9, 1, 1, 9);
        #2; check("sat_wb_same_cycle", 32'(id_ready_go), 32'd0);
        tick();
        drive(1, 0, 0, 0, 9, 1, 0, 0);
        #2; check("sat_release", 32'(id_to_exe_valid), 32'd1);
        tick();
        for (int k = 0; k < 8 && m_cnt[9] > 0; k++) begin
            drive(0, 0, 0, 0, 0, 1, 1, 9);
            tick();
        end
        idle();
        #2; check("r9_drained", 32'(pending[9]), 32'd0);
        tick();

        // Two sources, second one pending
        drive(1, 0, 0, 0, 20, 1, 0, 0);
        tick();
        drive(1, 0, 3, 20, 21, 1, 0, 0);
        #2; check("src2_stall", 32'(id_ready_go), 32'd0);
        tick();
        drive(1, 0, 3, 20, 21, 1, 1, 20);
        tick();
        drive(1, 0, 3, 20, 21, 1, 0, 0);
        #2; check("src2_release", 32'(id_to_exe_valid), 32'd1);
        tick();

        // Mid-operation reset discards in-flight writes (r21 still pending)
        drive(1, 0, 0, 0, 4, 1, 0, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2; check("midrst_pending", pending, 32'd0);
        check("midrst_stall", 32'(stall_cycles), 32'd0);
        tick();
        tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
